// File: rtl/fighter_pkg.sv
// Shared fighter game-logic definitions: facing FSM encodings and screen defaults.
// Other game-logic blocks import this package too.
package fighter_pkg;

   localparam int COORD_W_DEF  = 7;
   localparam int GROUND_Y_DEF = 50;

   typedef logic [1:0] facing_state_t;

   localparam facing_state_t ST_NORMAL    = 2'd0;
   localparam facing_state_t ST_PEND_SWAP = 2'd1;
   localparam facing_state_t ST_SWAPPED   = 2'd2;
   localparam facing_state_t ST_PEND_NORM = 2'd3;

   function automatic logic is_pend(input facing_state_t s);
      return (s == ST_PEND_SWAP) || (s == ST_PEND_NORM);
   endfunction

   // Sprite1 keeps its old facing until a PEND state completes.
   function automatic logic faces_right(input facing_state_t s);
      return (s == ST_NORMAL) || (s == ST_PEND_SWAP);
   endfunction

endpackage

// File: rtl/facing_controller_if.sv
// Bundle between movement/physics and the facing controller.
// The master is the game-logic side; the slave is the facing controller.
interface facing_controller_if import fighter_pkg::*; #(
   parameter int COORD_W = COORD_W_DEF
) ();

   logic               frame_tick;
   logic [COORD_W-1:0] sprite1_x;
   logic [COORD_W-1:0] sprite2_x;
   logic [COORD_W-1:0] sprite1_y;
   logic [COORD_W-1:0] sprite2_y;
   logic               sprite1_lock;
   logic               sprite2_lock;
   logic               sprite1_facing_right;
   logic               sprite2_facing_right;
   logic               turn_pulse;
   logic               turn_pending;

   modport master (
      output frame_tick, sprite1_x, sprite2_x, sprite1_y, sprite2_y,
             sprite1_lock, sprite2_lock,
      input  sprite1_facing_right, sprite2_facing_right, turn_pulse, turn_pending
   );

   modport slave (
      input  frame_tick, sprite1_x, sprite2_x, sprite1_y, sprite2_y,
             sprite1_lock, sprite2_lock,
      output sprite1_facing_right, sprite2_facing_right, turn_pulse, turn_pending
   );

endinterface

// File: rtl/facing_turn_timer.sv
// Frame counter shared by both PEND states; done flags the last frame before a turn.
// Counts only on tick, clears on demand, and saturates instead of wrapping.
module facing_turn_timer #(
   parameter int TURN_DELAY = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic tick,
   output logic done
);

   localparam int CNT_W = $clog2(TURN_DELAY + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TURN_DELAY);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TURN_DELAY - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (tick && (count_q != CNT_MAX)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done = (count_q == CNT_LAST);

endmodule

// File: rtl/facing_controller.sv
// Registered facing decision for both fighters, with a deadband, a frame-counted
// turn delay, and a turn lock while either fighter is airborne or attacking.
module facing_controller import fighter_pkg::*; #(
   parameter int COORD_W    = COORD_W_DEF,
   parameter int DEADBAND   = 2,
   parameter int TURN_DELAY = 4,
   parameter int GROUND_Y   = GROUND_Y_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   facing_controller_if.slave bus
);

   localparam logic signed [COORD_W:0] DB_S   = (COORD_W+1)'(DEADBAND);
   localparam logic [COORD_W-1:0]      GROUND = COORD_W'(GROUND_Y);

   logic signed [COORD_W:0] diff;
   logic signed [COORD_W:0] neg_diff;
   logic                    want_swap;
   logic                    want_norm;
   logic                    blocked;

   facing_state_t state_q;
   facing_state_t state_d;
   logic          facing_q;
   logic          facing_d;
   logic          pulse_q;
   logic          pulse_d;
   logic          pending_q;
   logic          pending_d;

   logic timer_clear;
   logic timer_tick;
   logic timer_done;

   // Zero-extended subtraction keeps 0 and max-coordinate as ordinary values.
   assign diff      = $signed({1'b0, bus.sprite1_x} - {1'b0, bus.sprite2_x});
   assign neg_diff  = -diff;
   assign want_swap = diff > DB_S;
   assign want_norm = neg_diff > DB_S;
   assign blocked   = bus.sprite1_lock | bus.sprite2_lock |
                      (bus.sprite1_y < GROUND) | (bus.sprite2_y < GROUND);

   facing_turn_timer #(
      .TURN_DELAY (TURN_DELAY)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (timer_clear),
      .tick  (timer_tick),
      .done  (timer_done)
   );

   // Cancel is checked before the final tick so a same-cycle cancel wins.
   always_comb begin
      state_d     = state_q;
      timer_clear = 1'b1;
      timer_tick  = 1'b0;
      case (state_q)
         ST_NORMAL: begin
            if (want_swap && !blocked) state_d = ST_PEND_SWAP;
         end
         ST_PEND_SWAP: begin
            if (!want_swap || blocked) begin
               state_d = ST_NORMAL;
            end else begin
               timer_clear = 1'b0;
               timer_tick  = bus.frame_tick;
               if (bus.frame_tick && timer_done) begin
                  state_d     = ST_SWAPPED;
                  timer_clear = 1'b1;
               end
            end
         end
         ST_SWAPPED: begin
            if (want_norm && !blocked) state_d = ST_PEND_NORM;
         end
         ST_PEND_NORM: begin
            if (!want_norm || blocked) begin
               state_d = ST_SWAPPED;
            end else begin
               timer_clear = 1'b0;
               timer_tick  = bus.frame_tick;
               if (bus.frame_tick && timer_done) begin
                  state_d     = ST_NORMAL;
                  timer_clear = 1'b1;
               end
            end
         end
         default: state_d = ST_NORMAL;
      endcase
   end

   always_comb begin
      facing_d  = faces_right(state_d);
      pulse_d   = facing_d != facing_q;
      pending_d = is_pend(state_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_NORMAL;
         facing_q  <= 1'b1;
         pulse_q   <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         facing_q  <= facing_d;
         pulse_q   <= pulse_d;
         pending_q <= pending_d;
      end
   end

   assign bus.sprite1_facing_right = facing_q;
   assign bus.sprite2_facing_right = ~facing_q;
   assign bus.turn_pulse           = pulse_q;
   assign bus.turn_pending         = pending_q;

endmodule
